// File: rtl/rock_pkg.sv
// Shared types and level-stepping helpers for the rocking-cradle controller.
package rock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOOTHE,
        HOLD,
        DECAY,
        FAULT
    } rock_state_t;

    localparam int DEF_LEVEL_W = 3;

    typedef logic [DEF_LEVEL_W-1:0] level_t;

    // Wide enough for any practical LEVEL_W; callers narrow the result.
    typedef struct packed {
        logic [15:0] amp;
        logic [15:0] freq;
    } level_pair_t;

    function automatic level_pair_t step_up(level_pair_t l, logic [15:0] max);
        level_pair_t r;
        r = l;
        if (l.freq < max) begin
            r.freq = l.freq + 16'd1;
        end else if (l.amp < max) begin
            r.amp = l.amp + 16'd1;
        end
        return r;
    endfunction

    function automatic level_pair_t step_down(level_pair_t l);
        level_pair_t r;
        r = l;
        if (l.amp != 16'd0) begin
            r.amp = l.amp - 16'd1;
        end else if (l.freq != 16'd0) begin
            r.freq = l.freq - 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rock_dwell_timer.sv
// Tick-qualified dwell counter with clear, saturation and terminal-count compare.
module rock_dwell_timer
    import rock_pkg::*;
#(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clear,
    input  logic [W-1:0] target,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && count != W'(MAX)) begin
            count <= count + W'(1);
        end
    end

    // Fires on the tick that brings the count up to target.
    assign done = tick && ({1'b0, count} + (W+1)'(1) >= {1'b0, target});

endmodule

// File: rtl/rock_ctrl.sv
// Rocking-cradle controller: soothe/hold/decay level stepping on a slow tick.
// Define ROCK_CTRL_FAULT_EN to build in the full-level watchdog and FAULT state.
module rock_ctrl
    import rock_pkg::*;
#(
    parameter int LEVEL_W    = 3,
    parameter int STEP_TICKS = 4,
    parameter int CALM_TICKS = 16,
    parameter int ERR_TICKS  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic               stress,
    output logic [LEVEL_W-1:0] amp,
    output logic [LEVEL_W-1:0] freq,
    output logic               active,
    output logic               error
);

`ifdef ROCK_CTRL_FAULT_EN
    localparam int CNT_MAX = (CALM_TICKS > ERR_TICKS) ? CALM_TICKS : ERR_TICKS;
    localparam int FULL_TICKS = ERR_TICKS;
`else
    localparam int CNT_MAX = CALM_TICKS;
    localparam int FULL_TICKS = (ERR_TICKS < CALM_TICKS) ? ERR_TICKS : CALM_TICKS;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

    rock_state_t        state_q;
    rock_state_t        state_d;
    logic [LEVEL_W-1:0] amp_d;
    logic [LEVEL_W-1:0] freq_d;
    logic               clear;
    logic               done;
    logic [CNT_W-1:0]   target;
    logic               full;
    level_pair_t        cur;
    level_pair_t        up;
    level_pair_t        dn;

    assign cur.amp  = 16'(amp);
    assign cur.freq = 16'(freq);
    assign up       = step_up(cur, 16'(LVL_MAX));
    assign dn       = step_down(cur);
    assign full     = (amp == LVL_MAX) && (freq == LVL_MAX);

    always_comb begin
        target = CNT_W'(STEP_TICKS);
        if (state_q == HOLD) begin
            target = CNT_W'(CALM_TICKS);
        end else if (state_q == SOOTHE && full) begin
            target = CNT_W'(FULL_TICKS);
        end
    end

    rock_dwell_timer #(
        .MAX (CNT_MAX),
        .W   (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .clear  (clear),
        .target (target),
        .done   (done)
    );

    always_comb begin
        state_d = state_q;
        amp_d   = amp;
        freq_d  = freq;
        clear   = 1'b0;
        if (!start) begin
            state_d = IDLE;
            amp_d   = '0;
            freq_d  = '0;
            clear   = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (stress) begin
                        state_d = SOOTHE;
                        amp_d   = '0;
                        freq_d  = LEVEL_W'(1);
                        clear   = 1'b1;
                    end
                end
                SOOTHE: begin
                    if (!stress) begin
                        state_d = HOLD;
                        clear   = 1'b1;
                    end else if (full) begin
`ifdef ROCK_CTRL_FAULT_EN
                        if (done) begin
                            state_d = FAULT;
                            amp_d   = '0;
                            freq_d  = '0;
                            clear   = 1'b1;
                        end
`endif
                    end else if (done) begin
                        amp_d  = LEVEL_W'(up.amp);
                        freq_d = LEVEL_W'(up.freq);
                        clear  = 1'b1;
                    end
                end
                HOLD: begin
                    if (stress) begin
                        state_d = SOOTHE;
                        clear   = 1'b1;
                    end else if (done) begin
                        state_d = DECAY;
                        clear   = 1'b1;
                    end
                end
                DECAY: begin
                    if (stress) begin
                        state_d = SOOTHE;
                        clear   = 1'b1;
                    end else if (done) begin
                        amp_d  = LEVEL_W'(dn.amp);
                        freq_d = LEVEL_W'(dn.freq);
                        clear  = 1'b1;
                        if (dn.amp == 16'd0 && dn.freq == 16'd0) begin
                            state_d = IDLE;
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            amp     <= '0;
            freq    <= '0;
        end else begin
            state_q <= state_d;
            amp     <= amp_d;
            freq    <= freq_d;
        end
    end

    assign active = (state_q != IDLE) && (state_q != FAULT);

`ifdef ROCK_CTRL_FAULT_EN
    assign error = (state_q == FAULT);
`else
    assign error = 1'b0;
`endif

endmodule
